// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
//   Shared definitions for the vending-machine sequencer slice.
//   - state_e       : sequencer state enum with fixed 4-bit encodings; the
//                     encoding is exported on state_o for the display, so the
//                     values must stay stable.
//   - TIMEOUT_CYC_DFLT / TMR_W_DFLT : default SELECT inactivity limit
//                     (30 s at 50 MHz) and the counter width that holds it.
//   - CREDIT_W      : credit width in 0.5 r units (sum never exceeds 1999).
//   - PROD_W        : product number width (1..12, 0 = none).
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int unsigned TIMEOUT_CYC_DFLT = 32'd1_500_000_000;
    localparam int unsigned TMR_W_DFLT       = 31;
    localparam int unsigned CREDIT_W         = 11;
    localparam int unsigned PROD_W           = 4;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SELECT     = 4'd1,
        ST_COIN_CHK   = 4'd2,
        ST_COIN_ADD   = 4'd3,
        ST_PAY_CHK    = 4'd4,
        ST_PAY        = 4'd5,
        ST_DISPENSE   = 4'd6,
        ST_CHARGE     = 4'd7,
        ST_CHARGE_CLR = 4'd8
    } state_e;

endpackage

// File: rtl/vend_idle_timer.sv
// -----------------------------------------------------------------------------
// vend_idle_timer
//   Inactivity counter for the SELECT state.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clr_i        : synchronous clear (dominates en_i)
//     en_i         : count enable
//     expire_o     : high in the cycle the count sits at TIMEOUT_CYC-1 while
//                    enabled and not being cleared
//   The counter saturates at TIMEOUT_CYC-1, so a missed expiry can never wrap
//   back to zero and silently restart the window. TMR_W must satisfy
//   2^TMR_W > TIMEOUT_CYC.
// -----------------------------------------------------------------------------
module vend_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = vend_pkg::TIMEOUT_CYC_DFLT,
    parameter int unsigned TMR_W       = vend_pkg::TMR_W_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_last) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // User activity in the same cycle as the deadline restarts the window
    // instead of timing out.
    assign expire_o = en_i && !clr_i && at_last;

endmodule

// File: rtl/vend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vend_seq_ctrl
//   Top-level transaction sequencer for the vending machine. Consumes touch
//   event pulses and status from the touch/coin datapath, drives the
//   datapath's state qualifiers, and runs the dispense / change-return
//   handshakes with the mechanism drivers.
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     select_flag           : product area touched (acted on in IDLE only)
//     sure_flag, cancel_flag, coin_sig, charge_flag : one-cycle event pulses
//     coin_ov_flag          : pending coin would overflow (valid in COIN_CHK)
//     nonenough_flag        : credit below price (valid in PAY_CHK)
//     coin_val_sum          : current credit, 0.5 r units
//     product_number        : selected product, 0 = none
//     disp_ack, change_ack  : mechanism completion pulses
//     selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag,
//     pay_st_flag, charge_st_flag : datapath qualifiers (state decodes)
//     disp_req / disp_prod  : dispense request and latched product
//     change_req / change_amt : change request and latched amount
//     coin_rej, short_pulse, timeout_pulse : registered one-cycle UI pulses
//     state_o               : current state encoding for the display
//
//   Handshake semantics (dispense and change return): the request is a level
//   that rises on entry to the wait state and stays high, with its payload
//   (disp_prod / change_amt) held stable, until the matching ack pulse is
//   sampled high; the request drops in the very next cycle. An ack sampled
//   while its request is low is ignored. Reset drops a request at once and the
//   transaction is abandoned.
//
//   Events arriving in a state that does not consume them are dropped, never
//   queued. Qualifiers and requests are pure decodes of the state register;
//   nothing on the output side depends combinationally on an input.
// -----------------------------------------------------------------------------
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
    parameter int unsigned TMR_W       = TMR_W_DFLT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                select_flag,
    input  logic                sure_flag,
    input  logic                cancel_flag,
    input  logic                coin_sig,
    input  logic                charge_flag,
    input  logic                coin_ov_flag,
    input  logic                nonenough_flag,
    input  logic [CREDIT_W-1:0] coin_val_sum,
    input  logic [PROD_W-1:0]   product_number,
    input  logic                disp_ack,
    input  logic                change_ack,
    output logic                selected_sta_flag,
    output logic                coin_sta_flag,
    output logic                coin_fn_flag,
    output logic                pay_sta_flag,
    output logic                pay_st_flag,
    output logic                charge_st_flag,
    output logic                disp_req,
    output logic [PROD_W-1:0]   disp_prod,
    output logic                change_req,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_rej,
    output logic                short_pulse,
    output logic                timeout_pulse,
    output logic [3:0]          state_o
);

    state_e               state_q;
    state_e               ret_q;          // state to resume after a coin check
    logic                 ov_q;           // overflow verdict captured in COIN_CHK
    logic [PROD_W-1:0]    disp_prod_q;
    logic [CREDIT_W-1:0]  change_amt_q;
    logic                 coin_rej_q;
    logic                 short_q;
    logic                 timeout_q;

    logic                 in_select;
    logic                 sure_ok;
    logic                 tmr_clr;
    logic                 tmr_expire;

    assign in_select = (state_q == ST_SELECT);
    assign sure_ok   = sure_flag && (product_number != '0);

    // ------------------------------------------------------------------
    // SELECT inactivity timer: held at zero outside SELECT, so it is
    // already clear on every SELECT entry; sure/coin touches restart it.
    // ------------------------------------------------------------------
    assign tmr_clr = !in_select || sure_flag || coin_sig;

    vend_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (in_select),
        .expire_o (tmr_expire)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered pulse outputs and latched payloads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            ov_q         <= 1'b0;
            disp_prod_q  <= '0;
            change_amt_q <= '0;
            coin_rej_q   <= 1'b0;
            short_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // Pulses default low; a transition below raises one for the
            // first cycle of the state being entered.
            coin_rej_q <= 1'b0;
            short_q    <= 1'b0;
            timeout_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (select_flag) begin
                        state_q <= ST_SELECT;
                    end else if (coin_sig) begin
                        state_q <= ST_COIN_CHK;
                        ret_q   <= ST_IDLE;
                    end else if (charge_flag && (coin_val_sum != '0)) begin
                        state_q      <= ST_CHARGE;
                        change_amt_q <= coin_val_sum;
                    end
                end

                // cancel > sure > coin > timeout. A sure with no product
                // chosen is not a purchase, but still counts as activity.
                ST_SELECT: begin
                    if (cancel_flag) begin
                        state_q <= ST_IDLE;
                    end else if (sure_ok) begin
                        state_q <= ST_PAY_CHK;
                    end else if (coin_sig) begin
                        state_q <= ST_COIN_CHK;
                        ret_q   <= ST_SELECT;
                    end else if (tmr_expire) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end
                end

                ST_COIN_CHK: begin
                    ov_q       <= coin_ov_flag;
                    coin_rej_q <= coin_ov_flag;
                    state_q    <= ST_COIN_ADD;
                end

                ST_COIN_ADD: begin
                    state_q <= ret_q;
                end

                // Product is captured here because the datapath clears it
                // during PAY.
                ST_PAY_CHK: begin
                    disp_prod_q <= product_number;
                    if (nonenough_flag) begin
                        state_q <= ST_SELECT;
                        short_q <= 1'b1;
                    end else begin
                        state_q <= ST_PAY;
                    end
                end

                ST_PAY: begin
                    state_q <= ST_DISPENSE;
                end

                ST_DISPENSE: begin
                    if (disp_ack) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_CHARGE: begin
                    if (change_ack) begin
                        state_q <= ST_CHARGE_CLR;
                    end
                end

                ST_CHARGE_CLR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state only.
    // ------------------------------------------------------------------
    assign selected_sta_flag = in_select;
    assign coin_sta_flag     = (state_q == ST_COIN_CHK);
    assign coin_fn_flag      = (state_q == ST_COIN_ADD) && !ov_q;
    assign pay_sta_flag      = (state_q == ST_PAY_CHK) || (state_q == ST_PAY);
    assign pay_st_flag       = (state_q == ST_PAY);
    assign charge_st_flag    = (state_q == ST_CHARGE_CLR);
    assign disp_req          = (state_q == ST_DISPENSE);
    assign change_req        = (state_q == ST_CHARGE);
    assign disp_prod         = disp_prod_q;
    assign change_amt        = change_amt_q;
    assign coin_rej          = coin_rej_q;
    assign short_pulse       = short_q;
    assign timeout_pulse     = timeout_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_seq_ctrl
//   Directed bench for vend_seq_ctrl with a small SELECT timeout. Expected
//   per-cycle snapshots {state, flags} are queued as stimulus is applied and
//   popped as each following cycle is observed (1 time unit after posedge).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vend_seq_ctrl;

    localparam int unsigned TO  = 16;
    localparam int unsigned TW  = 5;

    // Display state codes
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SEL  = 4'd1;
    localparam logic [3:0] S_CCHK = 4'd2;
    localparam logic [3:0] S_CADD = 4'd3;
    localparam logic [3:0] S_PCHK = 4'd4;
    localparam logic [3:0] S_PAY  = 4'd5;
    localparam logic [3:0] S_DISP = 4'd6;
    localparam logic [3:0] S_CHG  = 4'd7;
    localparam logic [3:0] S_CCLR = 4'd8;

    // Flag masks in snapshot order
    localparam logic [10:0] F_NONE  = 11'h000;
    localparam logic [10:0] F_SEL   = 11'h400;
    localparam logic [10:0] F_COIN  = 11'h200;
    localparam logic [10:0] F_FN    = 11'h100;
    localparam logic [10:0] F_PSTA  = 11'h080;
    localparam logic [10:0] F_PST   = 11'h040;
    localparam logic [10:0] F_CST   = 11'h020;
    localparam logic [10:0] F_DREQ  = 11'h010;
    localparam logic [10:0] F_CREQ  = 11'h008;
    localparam logic [10:0] F_REJ   = 11'h004;
    localparam logic [10:0] F_SHORT = 11'h002;
    localparam logic [10:0] F_TO    = 11'h001;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        select_flag, sure_flag, cancel_flag, coin_sig, charge_flag;
    logic        coin_ov_flag, nonenough_flag;
    logic [10:0] coin_val_sum;
    logic [3:0]  product_number;
    logic        disp_ack, change_ack;
    logic        selected_sta_flag, coin_sta_flag, coin_fn_flag, pay_sta_flag;
    logic        pay_st_flag, charge_st_flag, disp_req, change_req;
    logic [3:0]  disp_prod;
    logic [10:0] change_amt;
    logic        coin_rej, short_pulse, timeout_pulse;
    logic [3:0]  state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vend_seq_ctrl #(
        .TIMEOUT_CYC (TO),
        .TMR_W       (TW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .select_flag       (select_flag),
        .sure_flag         (sure_flag),
        .cancel_flag       (cancel_flag),
        .coin_sig          (coin_sig),
        .charge_flag       (charge_flag),
        .coin_ov_flag      (coin_ov_flag),
        .nonenough_flag    (nonenough_flag),
        .coin_val_sum      (coin_val_sum),
        .product_number    (product_number),
        .disp_ack          (disp_ack),
        .change_ack        (change_ack),
        .selected_sta_flag (selected_sta_flag),
        .coin_sta_flag     (coin_sta_flag),
        .coin_fn_flag      (coin_fn_flag),
        .pay_sta_flag      (pay_sta_flag),
        .pay_st_flag       (pay_st_flag),
        .charge_st_flag    (charge_st_flag),
        .disp_req          (disp_req),
        .disp_prod         (disp_prod),
        .change_req        (change_req),
        .change_amt        (change_amt),
        .coin_rej          (coin_rej),
        .short_pulse       (short_pulse),
        .timeout_pulse     (timeout_pulse),
        .state_o           (state_o)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [15:0] snap();
        return {1'b0, state_o, selected_sta_flag, coin_sta_flag, coin_fn_flag,
                pay_sta_flag, pay_st_flag, charge_st_flag, disp_req, change_req,
                coin_rej, short_pulse, timeout_pulse};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [10:0] fl);
        exp_q.push_back({1'b0, st, fl});
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s: observed %0h expected <empty queue>", tag, snap());
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(snap()), 32'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag);
        step();
        pop_chk(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200us");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [3:0] rnd_prod;

    initial begin
        rst_n          = 1'b0;
        select_flag    = 1'b0;
        sure_flag      = 1'b0;
        cancel_flag    = 1'b0;
        coin_sig       = 1'b0;
        charge_flag    = 1'b0;
        coin_ov_flag   = 1'b0;
        nonenough_flag = 1'b0;
        coin_val_sum   = '0;
        product_number = '0;
        disp_ack       = 1'b0;
        change_ack     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        push(S_IDLE, F_NONE);
        pop_chk("reset_outputs");
        chk("reset_disp_prod", 32'(disp_prod), 32'd0);
        chk("reset_change_amt", 32'(change_amt), 32'd0);
        rst_n = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("idle_after_reset");

        // Coin from IDLE, no overflow; a second coin during COIN_CHK is dropped
        coin_sig = 1'b1;
        push(S_CCHK, F_COIN);
        push(S_CADD, F_FN);
        push(S_IDLE, F_NONE);
        push(S_IDLE, F_NONE);
        step_chk("coin_t1");
        step_chk("coin_t2");
        coin_sig = 1'b0;
        step_chk("coin_t3_idle");
        step_chk("coin_retrigger_dropped");

        // Enter SELECT, coin with overflow
        select_flag = 1'b1;
        push(S_SEL, F_SEL);
        step_chk("enter_select");
        select_flag = 1'b0;
        coin_sig = 1'b1;
        push(S_CCHK, F_COIN);
        step_chk("ovf_chk");
        coin_sig = 1'b0;
        coin_ov_flag = 1'b1;
        push(S_CADD, F_REJ);
        step_chk("ovf_reject");
        coin_ov_flag = 1'b0;
        push(S_SEL, F_SEL);
        step_chk("ovf_back_select");

        // Insufficient credit
        product_number = 4'd6;
        sure_flag = 1'b1;
        push(S_PCHK, F_PSTA);
        step_chk("short_pay_chk");
        sure_flag = 1'b0;
        nonenough_flag = 1'b1;
        push(S_SEL, F_SEL | F_SHORT);
        step_chk("short_pulse");
        nonenough_flag = 1'b0;
        push(S_SEL, F_SEL);
        step_chk("short_done");

        // Purchase of product 6
        sure_flag = 1'b1;
        push(S_PCHK, F_PSTA);
        step_chk("buy_pay_chk");
        sure_flag = 1'b0;
        push(S_PAY, F_PSTA | F_PST);
        step_chk("buy_pay");
        product_number = 4'd0;
        push(S_DISP, F_DREQ);
        step_chk("buy_dispense");
        chk("buy_disp_prod", 32'(disp_prod), 32'd6);
        push(S_DISP, F_DREQ);
        step_chk("buy_dispense_hold");
        disp_ack = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("buy_ack_idle");
        disp_ack = 1'b0;

        // Stray acks in IDLE
        disp_ack = 1'b1;
        change_ack = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("stray_ack_ignored");
        disp_ack = 1'b0;
        change_ack = 1'b0;

        // Change return of 37
        coin_val_sum = 11'd37;
        charge_flag = 1'b1;
        push(S_CHG, F_CREQ);
        step_chk("chg_req");
        charge_flag = 1'b0;
        chk("chg_amt", 32'(change_amt), 32'd37);
        coin_val_sum = 11'd0;
        push(S_CHG, F_CREQ);
        step_chk("chg_hold");
        chk("chg_amt_hold", 32'(change_amt), 32'd37);
        change_ack = 1'b1;
        push(S_CCLR, F_CST);
        step_chk("chg_clr");
        change_ack = 1'b0;
        push(S_IDLE, F_NONE);
        step_chk("chg_idle");
        charge_flag = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("chg_zero_ignored");
        charge_flag = 1'b0;

        // SELECT timeout after TO cycles
        select_flag = 1'b1;
        push(S_SEL, F_SEL);
        step_chk("to_enter");
        select_flag = 1'b0;
        for (int i = 1; i < int'(TO); i++) push(S_SEL, F_SEL);
        push(S_IDLE, F_TO);
        push(S_IDLE, F_NONE);
        for (int i = 0; i < int'(TO) + 1; i++) step_chk("to_wait");

        // Timeout coinciding with sure: sure wins
        select_flag = 1'b1;
        push(S_SEL, F_SEL);
        step_chk("race_enter");
        select_flag = 1'b0;
        for (int i = 1; i < int'(TO); i++) begin
            push(S_SEL, F_SEL);
            step_chk("race_wait");
        end
        product_number = 4'd3;
        sure_flag = 1'b1;
        push(S_PCHK, F_PSTA);
        step_chk("race_sure_wins");
        sure_flag = 1'b0;
        nonenough_flag = 1'b1;
        push(S_SEL, F_SEL | F_SHORT);
        step_chk("race_short");
        nonenough_flag = 1'b0;
        cancel_flag = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("cancel_idle");
        cancel_flag = 1'b0;

        // Reset mid-DISPENSE
        select_flag = 1'b1;
        push(S_SEL, F_SEL);
        step_chk("rst_enter_select");
        select_flag = 1'b0;
        rnd_prod = 4'($urandom_range(12, 1));
        product_number = rnd_prod;
        sure_flag = 1'b1;
        push(S_PCHK, F_PSTA);
        step_chk("rst_pay_chk");
        sure_flag = 1'b0;
        push(S_PAY, F_PSTA | F_PST);
        step_chk("rst_pay");
        product_number = 4'd0;
        push(S_DISP, F_DREQ);
        step_chk("rst_dispense");
        chk("rst_disp_prod", 32'(disp_prod), 32'(rnd_prod));
        #2;
        rst_n = 1'b0;
        #1;
        push(S_IDLE, F_NONE);
        pop_chk("rst_mid_dispense");
        chk("rst_disp_prod_clr", 32'(disp_prod), 32'd0);
        rst_n = 1'b1;
        push(S_IDLE, F_NONE);
        step_chk("rst_no_resume");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
